// File: rtl/is_pkg_uart_controller.sv
// Shared constants and state encoding for the UART controller.
// Optional parity support elsewhere is selected with UART_RX_PARITY_EN.
package is_pkg_uart_controller;

  localparam int RATIO         = 8;
  localparam int DATA_BITS_DEF = 8;

  // PARITY exists in every build so the state encoding never shifts
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/is_uart_rx_sync.sv
// rxd synchroniser chain plus one delay flop for falling-edge detection.
// Everything resets to the idle line level so reset never fakes an edge.
module is_uart_rx_sync
  import is_pkg_uart_controller::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_d_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q  <= '1;
      rxd_d_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd_i};
      rxd_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxd_s_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = rxd_d_q & ~rxd_s_o;

endmodule

// File: rtl/is_uart_rx_ctrl.sv
// UART receive frame controller: start detect, bit sampling, result pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module is_uart_rx_ctrl
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rxd_i,
  input  logic                 rx_ce_i,
  output logic                 rxct_r_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_frm_err_o,
  output logic                 rx_par_err_o,
  output logic                 rx_busy_o
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frm_q, frm_d;
  logic                 rxd_s, fall;

  is_uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .rxd_i  (rxd_i),
    .rxd_s_o(rxd_s),
    .fall_o (fall)
  );

`ifdef UART_RX_PARITY_EN
  logic parbad_q, parbad_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    frm_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parbad_d = parbad_q;
    perr_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (rx_ce_i) begin
          if (!rxd_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (rx_ce_i) begin
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (rx_ce_i) begin
          parbad_d = ^shift_q ^ rxd_s;
          state_d  = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (rx_ce_i) begin
          state_d = IDLE;
          if (!rxd_s) begin
            frm_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parbad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      frm_q   <= frm_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      parbad_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      parbad_q <= parbad_d;
      perr_q   <= perr_d;
    end
  end
  assign rx_par_err_o = perr_q;
`else
  assign rx_par_err_o = 1'b0;
`endif

  // Pure state decode keeps the counter clear glitch-free
  assign rxct_r_o     = (state_q == IDLE);
  assign rx_busy_o    = (state_q != IDLE);
  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign rx_frm_err_o = frm_q;

endmodule

// File: doc/is_uart_rx_ctrl.md
Name: is_uart_rx_ctrl

Overview:
- Receive-side frame controller of the UART.
- Consumes the mid-bit sample strobe rx_ce from the RX sample counter and drives that counter's clear input (rxct_r).
- Detects the start edge, samples start/data/(parity)/stop bits, and delivers a received byte with a one-cycle valid pulse or an error pulse.
- Sits between the raw rxd pad and the register/FIFO interface of the UART controller.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.
- SYNC_STAGES, 2, depth of the rxd synchroniser; minimum 2.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- rxd_i  in  1  asynchronous serial input; idle level 1
- rx_ce_i  in  1  mid-bit sample strobe from the RX sample counter; one clk_i cycle wide
- rxct_r_o  out  1  clear/hold for the RX sample counter; high = counter held at 0
- rx_data_o  out  DATA_BITS  last correctly received byte
- rx_valid_o  out  1  one-cycle pulse: rx_data_o updated
- rx_frm_err_o  out  1  one-cycle pulse: stop bit sampled as 0
- rx_par_err_o  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out
- rx_busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state IDLE
  - synchroniser flops 1
  - rx_data_o 0
  - rx_valid_o, rx_frm_err_o, rx_par_err_o 0
  - rxct_r_o 1
  - rx_busy_o 0
- Synchroniser: rxd_i passes through SYNC_STAGES flops, producing rxd_s. One extra flop holds rxd_d. fall = rxd_d & ~rxd_s.
- rxct_r_o is a decode of the state register only: 1 iff state==IDLE. It is glitch-free, so the sample counter starts counting the cycle after leaving IDLE.
- State transitions:
  - IDLE: fall -> START. rx_ce_i is ignored.
  - START: on rx_ce_i, rxd_s==0 -> DATA with bit_cnt=0. rxd_s==1 (false start or glitch) -> IDLE, with no outputs.
  - DATA: on rx_ce_i, shift rxd_s into the MSB of the shift register (right shift, so LSB-first data lands aligned) and increment bit_cnt. When bit_cnt==DATA_BITS-1 -> PARITY if enabled, else STOP.
  - STOP: on rx_ce_i, rxd_s==1 -> rx_data_o <= shift register and rx_valid_o pulses the next cycle. rxd_s==0 -> rx_frm_err_o pulses and rx_data_o is unchanged. In both cases -> IDLE.
- Back-to-back frames: after returning to IDLE at stop mid-bit, a falling edge in the remaining half stop bit is detected normally.
- Pulse outputs are registered and exactly one cycle. rx_valid_o, rx_frm_err_o and rx_par_err_o are mutually exclusive.
- Width: bit_cnt is $clog2(DATA_BITS) bits and never wraps past DATA_BITS-1.
- Async reset mid-frame aborts the frame. No pulse is emitted, and rxct_r_o returns to 1 immediately.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - PARITY state inserted after DATA. Even parity: XOR of data bits and the parity bit must be 0.
  - On rx_ce_i in PARITY, record the mismatch -> STOP.
  - At STOP with stop==1: mismatch gives an rx_par_err_o pulse, no rx_valid_o, and rx_data_o unchanged. Otherwise the normal valid path is taken.
  - Framing error takes precedence over parity error.
- Undefined: no PARITY state, and rx_par_err_o is constant 0.

Decomposition:
- Package is_pkg_uart_controller holds:
  - RATIO
  - DATA_BITS default constant
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP}. PARITY is kept regardless of the macro, for a stable encoding.
- Sub-module is_uart_rx_sync: SYNC_STAGES synchroniser plus falling-edge detector. Outputs rxd_s and fall.

Test Plan (RATIO=8, uart_ce every 4 clk_i, real RX sample counter in loop):
1. Frame 0xA5, 8N1 -> rx_valid_o pulses once, rx_data_o=0xA5, both error flags 0, rxct_r_o high again after stop.
2. rxd low for 2 uart_ce ticks then high -> START sees 1, return to IDLE, no pulses, rx_data_o keeps its prior value.
3. Frame 0x3C with stop bit 0 -> rx_frm_err_o one-cycle pulse, rx_valid_o 0, rx_data_o unchanged (0xA5).
4. Frames 0x00 then 0xFF with no idle gap -> two rx_valid_o pulses, data 0x00 then 0xFF.
5. rstn_i asserted during data bit 4 of 0x55, then released and 0x55 resent -> immediate reset values, no pulse from the aborted frame, then one valid with 0x55.
6. UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_par_err_o pulse, no valid. 0x07 with parity bit 1 -> valid with 0x07.
